prv_trap_sequencer: RTL and testbench
=====================================

# prv_trap_sequencer

Pipeline-side controller for the privilege interface. It samples exception, return and WFI indications from the memory stage, picks one by fixed priority and waits out any outstanding data access. It then presents a single registered trap report to the privilege block (fault flags, epc, badaddr, pipe_clear) and converts the privilege block's `insert_pc`/`priv_pc` reply into a one-cycle pipeline flush and fetch redirect. It sits inside the hazard unit and drives the hazard-side signal set of the privilege/pipeline interface.

## Interface
Parameters:
- RESET_PC, 32'h0000_0200, value driven on `redirect_pc` and `epc` out of reset

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- mem_valid  in  1  memory-stage instruction valid
- mem_pc  in  32  memory-stage instruction PC
- mem_fault_insn, mem_mal_insn, mem_illegal_insn, mem_breakpoint, mem_env  in  1 each  sync exception flags
- mem_fault_l, mem_mal_l, mem_fault_s, mem_mal_s  in  1 each  data exception flags
- mem_ret, mem_wfi  in  1 each  xRET / WFI in memory stage
- mem_daddr  in  32  data address of the memory-stage access
- prot_fault_i, prot_fault_l, prot_fault_s  in  1 each  protection faults from privilege block, OR'd into fault_insn / fault_l / fault_s
- intr  in  1  pending enabled interrupt
- insert_pc  in  1  privilege block has a valid `priv_pc`
- priv_pc  in  32  trap vector or return target
- ex_mem_stall  in  1  data access still outstanding
- fault_insn, mal_insn, illegal_insn, breakpoint, env, fault_l, mal_l, fault_s, mal_s, ret, wfi  out  1 each  one-hot trap report to privilege block
- epc  out  32  reported exception PC
- badaddr  out  32  reported faulting address
- pipe_clear  out  1  report valid; pipeline is empty of younger instructions
- wb_enable  out  1  memory-stage instruction may commit
- hold_pipe  out  1  freeze all stages
- flush_all  out  1  squash IF–MEM
- redirect_valid  out  1  fetch must load `redirect_pc`
- redirect_pc  out  32  new fetch PC

## Operation
- States: IDLE, DRAIN, REPORT, AWAIT, REDIRECT, WFI_SLEEP.
- Event in IDLE: `mem_valid` and (any flag, `mem_ret`, or `mem_wfi`), or `intr`.
- Selection priority: intr > breakpoint > fault_insn > mal_insn > illegal_insn > env > mal_s > mal_l > fault_s > fault_l > ret > wfi. Exactly one report bit is set. Interrupts are reported with all flags low and `pipe_clear`=1.
- Latch on event: the selected cause, `epc`, and `badaddr`.
  - `epc` = mem_pc, or mem_pc+4 for an interrupt arriving in WFI_SLEEP.
  - `badaddr` = mem_daddr for l/s causes, mem_pc for insn causes, 0 otherwise.
- IDLE → DRAIN if `ex_mem_stall`, else → REPORT. DRAIN → REPORT on the first cycle `ex_mem_stall`=0.
- wfi selected: → WFI_SLEEP (report wfi for one cycle, then hold). WFI_SLEEP → REPORT as interrupt when `intr`=1.
- REPORT (1 cycle): drive report bits, `epc`, `badaddr`, `pipe_clear`=1; `flush_all`=1. → AWAIT, or straight to REDIRECT if `insert_pc` is already 1.
- AWAIT: `hold_pipe`=1 until `insert_pc`, then capture `priv_pc` → REDIRECT.
- REDIRECT (1 cycle): `redirect_valid`=1, `flush_all`=1 → IDLE.
- `wb_enable`=0 whenever a trap or interrupt is selected. `wb_enable`=1 for ret and for normal flow.
- Events arriving in non-IDLE states are ignored, since the pipeline is held or flushed.

## Timing
- Reset: state IDLE; all report bits, `pipe_clear`, `flush_all`, `redirect_valid`, `hold_pipe` = 0; `wb_enable`=1; `epc`=`redirect_pc`=RESET_PC; `badaddr`=0.
- Reset asserted mid-sequence aborts immediately to the reset state; no partial report is emitted.
- Report outputs are registered. Event sampled at edge N gives REPORT in cycle N+1 with no stall, or in cycle N+1+k after k stall cycles.
- Minimum event-to-redirect latency is 2 cycles, when `insert_pc` arrives in the REPORT cycle.
- `hold_pipe`=1 in DRAIN, AWAIT and WFI_SLEEP.
- `intr` and a sync flag in the same cycle: interrupt wins, and `epc`=mem_pc so the instruction re-executes.
- `insert_pc` held high for multiple cycles produces exactly one REDIRECT.

## Test plan
- Illegal insn: mem_pc=0x1000, illegal=1, no stall, `insert_pc`=1 in the REPORT cycle, priv_pc=0x80 → illegal_insn=1, epc=0x1000, badaddr=0x1000 at N+1; redirect_pc=0x80 with redirect_valid at N+2.
- Load fault with stall: fault_l=1, mem_daddr=0xDEAD_BEE0, ex_mem_stall high 3 cycles → REPORT at N+4 with badaddr=0xDEAD_BEE0; no report bits during DRAIN.
- Priority: intr=1, mal_s=1, breakpoint=1 together → interrupt report only (all flags 0, pipe_clear=1), epc=mem_pc, wb_enable=0.
- WFI: mem_wfi at pc 0x2000 → wfi pulse, hold_pipe high; intr after 10 cycles → report with epc=0x2004, then redirect to priv_pc.
- Reset in AWAIT: assert RST → all outputs at reset values the same cycle; a later `insert_pc` produces no redirect.

Source files
------------

// File: rtl/prv_trap_sequencer.sv
// Hazard-side trap sequencer: picks one memory-stage exception/return/WFI or interrupt,
// drains the outstanding data access, reports it once and turns the privilege reply into a redirect.
module prv_trap_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_fault_insn,
  input  logic        mem_mal_insn,
  input  logic        mem_illegal_insn,
  input  logic        mem_breakpoint,
  input  logic        mem_env,
  input  logic        mem_fault_l,
  input  logic        mem_mal_l,
  input  logic        mem_fault_s,
  input  logic        mem_mal_s,
  input  logic        mem_ret,
  input  logic        mem_wfi,
  input  logic [31:0] mem_daddr,
  input  logic        prot_fault_i,
  input  logic        prot_fault_l,
  input  logic        prot_fault_s,
  input  logic        intr,
  input  logic        insert_pc,
  input  logic [31:0] priv_pc,
  input  logic        ex_mem_stall,
  output logic        fault_insn,
  output logic        mal_insn,
  output logic        illegal_insn,
  output logic        breakpoint,
  output logic        env,
  output logic        fault_l,
  output logic        mal_l,
  output logic        fault_s,
  output logic        mal_s,
  output logic        ret,
  output logic        wfi,
  output logic [31:0] epc,
  output logic [31:0] badaddr,
  output logic        pipe_clear,
  output logic        wb_enable,
  output logic        hold_pipe,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_REPORT, S_AWAIT, S_REDIRECT, S_WFI_SLEEP
  } state_t;

  typedef enum logic [3:0] {
    C_INTR, C_BRK, C_FAULT_I, C_MAL_I, C_ILL, C_ENV,
    C_MAL_S, C_MAL_L, C_FAULT_S, C_FAULT_L, C_RET, C_WFI
  } cause_t;

  typedef struct packed {
    logic fault_insn, mal_insn, illegal_insn, breakpoint, env;
    logic fault_l, mal_l, fault_s, mal_s, ret, wfi;
  } report_t;

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d, sel_cause;
  report_t     rep_q;
  logic        pipe_clear_q;
  logic [31:0] epc_q, badaddr_q, redirect_pc_q, sel_bad;
  logic        sel_valid, latch_evt, wake, show;

  // Protection faults from the privilege block merge into the matching pipeline flags.
  logic f_fi, f_mi, f_ill, f_brk, f_env, f_fl, f_ml, f_fs, f_ms, f_ret, f_wfi;
  assign f_fi  = mem_valid & (mem_fault_insn | prot_fault_i);
  assign f_mi  = mem_valid & mem_mal_insn;
  assign f_ill = mem_valid & mem_illegal_insn;
  assign f_brk = mem_valid & mem_breakpoint;
  assign f_env = mem_valid & mem_env;
  assign f_fl  = mem_valid & (mem_fault_l | prot_fault_l);
  assign f_ml  = mem_valid & mem_mal_l;
  assign f_fs  = mem_valid & (mem_fault_s | prot_fault_s);
  assign f_ms  = mem_valid & mem_mal_s;
  assign f_ret = mem_valid & mem_ret;
  assign f_wfi = mem_valid & mem_wfi;

  assign sel_valid = intr | f_fi | f_mi | f_ill | f_brk | f_env | f_fl | f_ml |
                     f_fs | f_ms | f_ret | f_wfi;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_cause = C_WFI;
    if      (intr)  sel_cause = C_INTR;
    else if (f_brk) sel_cause = C_BRK;
    else if (f_fi)  sel_cause = C_FAULT_I;
    else if (f_mi)  sel_cause = C_MAL_I;
    else if (f_ill) sel_cause = C_ILL;
    else if (f_env) sel_cause = C_ENV;
    else if (f_ms)  sel_cause = C_MAL_S;
    else if (f_ml)  sel_cause = C_MAL_L;
    else if (f_fs)  sel_cause = C_FAULT_S;
    else if (f_fl)  sel_cause = C_FAULT_L;
    else if (f_ret) sel_cause = C_RET;

    sel_bad = 32'd0;
    case (sel_cause)
      C_BRK, C_FAULT_I, C_MAL_I, C_ILL:     sel_bad = mem_pc;
      C_MAL_S, C_MAL_L, C_FAULT_S, C_FAULT_L: sel_bad = mem_daddr;
      default:                               sel_bad = 32'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    latch_evt      = 1'b0;
    wake           = 1'b0;
    hold_pipe      = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    wb_enable      = 1'b1;
    case (state_q)
      S_IDLE: if (sel_valid) begin
        latch_evt = 1'b1;
        cause_d   = sel_cause;
        wb_enable = (sel_cause == C_RET) || (sel_cause == C_WFI);
        if (sel_cause == C_WFI) state_d = S_WFI_SLEEP;
        else if (ex_mem_stall)  state_d = S_DRAIN;
        else                    state_d = S_REPORT;
      end
      S_DRAIN: begin
        hold_pipe = 1'b1;
        wb_enable = (cause_q == C_RET);
        if (!ex_mem_stall) state_d = S_REPORT;
      end
      S_REPORT: begin
        flush_all = 1'b1;
        wb_enable = (cause_q == C_RET);
        state_d   = insert_pc ? S_REDIRECT : S_AWAIT;
      end
      S_AWAIT: begin
        hold_pipe = 1'b1;
        wb_enable = (cause_q == C_RET);
        if (insert_pc) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        flush_all      = 1'b1;
        state_d        = S_IDLE;
      end
      S_WFI_SLEEP: begin
        hold_pipe = 1'b1;
        if (intr) begin
          wake      = 1'b1;
          cause_d   = C_INTR;
          wb_enable = 1'b0;
          state_d   = S_REPORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The report is valid only in the REPORT cycle, plus the single wfi pulse on entering sleep.
  assign show = (state_d == S_REPORT) || (state_q == S_IDLE && state_d == S_WFI_SLEEP);

  function automatic report_t decode(input cause_t c);
    report_t r;
    r = '0;
    case (c)
      C_BRK:     r.breakpoint   = 1'b1;
      C_FAULT_I: r.fault_insn   = 1'b1;
      C_MAL_I:   r.mal_insn     = 1'b1;
      C_ILL:     r.illegal_insn = 1'b1;
      C_ENV:     r.env          = 1'b1;
      C_MAL_S:   r.mal_s        = 1'b1;
      C_MAL_L:   r.mal_l        = 1'b1;
      C_FAULT_S: r.fault_s      = 1'b1;
      C_FAULT_L: r.fault_l      = 1'b1;
      C_RET:     r.ret          = 1'b1;
      C_WFI:     r.wfi          = 1'b1;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cause_q       <= C_INTR;
      rep_q         <= '0;
      pipe_clear_q  <= 1'b0;
      epc_q         <= RESET_PC;
      badaddr_q     <= 32'd0;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      rep_q        <= show ? decode(cause_d) : '0;
      pipe_clear_q <= show;
      if (latch_evt) begin
        epc_q     <= mem_pc;
        badaddr_q <= sel_bad;
      end else if (wake) begin
        epc_q     <= mem_pc + 32'd4;
        badaddr_q <= 32'd0;
      end
      if ((state_q == S_REPORT || state_q == S_AWAIT) && insert_pc)
        redirect_pc_q <= priv_pc;
    end
  end

  assign {fault_insn, mal_insn, illegal_insn, breakpoint, env,
          fault_l, mal_l, fault_s, mal_s, ret, wfi} = rep_q;
  assign pipe_clear  = pipe_clear_q;
  assign epc         = epc_q;
  assign badaddr     = badaddr_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Self-checking bench for prv_trap_sequencer: directed sequences plus a cause table,
// with expected reports and redirects queued at stimulus time and compared when the DUT emits them.
module tb_prv_trap_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0200;

  // Report vector order: fault_insn .. wfi, matching the output port list.
  localparam logic [10:0] B_FI  = 11'h400, B_MI  = 11'h200, B_ILL = 11'h100,
                          B_BRK = 11'h080, B_ENV = 11'h040, B_FL  = 11'h020,
                          B_ML  = 11'h010, B_FS  = 11'h008, B_MS  = 11'h004,
                          B_RET = 11'h002, B_WFI = 11'h001;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_valid, intr, insert_pc, ex_mem_stall;
  logic [31:0] mem_pc, mem_daddr, priv_pc;
  logic [10:0] mem_flags;
  logic [2:0]  prot;
  logic        mem_fault_insn, mem_mal_insn, mem_illegal_insn, mem_breakpoint, mem_env;
  logic        mem_fault_l, mem_mal_l, mem_fault_s, mem_mal_s, mem_ret, mem_wfi;
  logic        prot_fault_i, prot_fault_l, prot_fault_s;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env;
  logic        fault_l, mal_l, fault_s, mal_s, ret, wfi;
  logic [31:0] epc, badaddr, redirect_pc;
  logic        pipe_clear, wb_enable, hold_pipe, flush_all, redirect_valid;
  logic [10:0] rep;

  assign {mem_fault_insn, mem_mal_insn, mem_illegal_insn, mem_breakpoint, mem_env,
          mem_fault_l, mem_mal_l, mem_fault_s, mem_mal_s, mem_ret, mem_wfi} = mem_flags;
  assign {prot_fault_i, prot_fault_l, prot_fault_s} = prot;
  assign rep = {fault_insn, mal_insn, illegal_insn, breakpoint, env,
                fault_l, mal_l, fault_s, mal_s, ret, wfi};

  always #5 CLK = ~CLK;

  prv_trap_sequencer #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST),
    .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_fault_insn(mem_fault_insn), .mem_mal_insn(mem_mal_insn),
    .mem_illegal_insn(mem_illegal_insn), .mem_breakpoint(mem_breakpoint), .mem_env(mem_env),
    .mem_fault_l(mem_fault_l), .mem_mal_l(mem_mal_l), .mem_fault_s(mem_fault_s), .mem_mal_s(mem_mal_s),
    .mem_ret(mem_ret), .mem_wfi(mem_wfi), .mem_daddr(mem_daddr),
    .prot_fault_i(prot_fault_i), .prot_fault_l(prot_fault_l), .prot_fault_s(prot_fault_s),
    .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc), .ex_mem_stall(ex_mem_stall),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .fault_l(fault_l), .mal_l(mal_l),
    .fault_s(fault_s), .mal_s(mal_s), .ret(ret), .wfi(wfi),
    .epc(epc), .badaddr(badaddr), .pipe_clear(pipe_clear), .wb_enable(wb_enable),
    .hold_pipe(hold_pipe), .flush_all(flush_all),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [10:0] rep;
    logic [31:0] epc;
    logic [31:0] bad;
    bit          chk_bad;
  } exp_t;

  exp_t        rep_sb[$];
  logic [31:0] redir_sb[$];

  task automatic push_rep(input logic [10:0] r, input logic [31:0] e,
                          input logic [31:0] b, input bit cb);
    exp_t x;
    x.rep = r; x.epc = e; x.bad = b; x.chk_bad = cb;
    rep_sb.push_back(x);
  endtask

  // Output monitor: every report and redirect the DUT emits must match a queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (pipe_clear) begin
        if (rep_sb.size() == 0) check("unexpected_report", 32'(pipe_clear), 32'd0);
        else begin
          e = rep_sb.pop_front();
          check("report_bits", 32'(rep), 32'(e.rep));
          check("report_epc", epc, e.epc);
          if (e.chk_bad) check("report_badaddr", badaddr, e.bad);
        end
      end else begin
        check("report_bits_quiet", 32'(rep), 32'd0);
      end
      if (redirect_valid) begin
        if (redir_sb.size() == 0) check("unexpected_redirect", 32'(redirect_valid), 32'd0);
        else check("redirect_pc", redirect_pc, redir_sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_flags = '0; prot = '0; intr = 1'b0;
  endtask

  typedef struct {
    logic [10:0] flags;
    logic [2:0]  prot;
    logic [10:0] exp;
    logic [1:0]  bk;   // 0: badaddr 0, 1: mem_pc, 2: mem_daddr, 3: not checked
  } tc_t;

  tc_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad;
    tbl[0]  = '{B_BRK | B_FI,  3'b000, B_BRK, 2'd3};
    tbl[1]  = '{B_FI | B_MI,   3'b000, B_FI,  2'd1};
    tbl[2]  = '{11'h000,       3'b100, B_FI,  2'd1};
    tbl[3]  = '{B_MI | B_ILL,  3'b000, B_MI,  2'd1};
    tbl[4]  = '{B_ENV | B_MS,  3'b000, B_ENV, 2'd0};
    tbl[5]  = '{B_MS | B_ML,   3'b000, B_MS,  2'd2};
    tbl[6]  = '{B_ML | B_FS,   3'b000, B_ML,  2'd2};
    tbl[7]  = '{B_FS | B_FL,   3'b000, B_FS,  2'd2};
    tbl[8]  = '{11'h000,       3'b001, B_FS,  2'd2};
    tbl[9]  = '{11'h000,       3'b010, B_FL,  2'd2};
    tbl[10] = '{B_FL | B_RET,  3'b000, B_FL,  2'd2};
    tbl[11] = '{B_RET | B_WFI, 3'b000, B_RET, 2'd0};

    RST = 1'b1; idle_inputs();
    mem_pc = '0; mem_daddr = '0; priv_pc = '0; insert_pc = 1'b0; ex_mem_stall = 1'b0;
    tick(); tick();
    check("rst_report", 32'(rep), 32'd0);
    check("rst_pipe_clear", 32'(pipe_clear), 32'd0);
    check("rst_flush", 32'(flush_all), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_hold", 32'(hold_pipe), 32'd0);
    check("rst_wb_enable", 32'(wb_enable), 32'd1);
    check("rst_epc", epc, RESET_PC);
    check("rst_redirect_pc", redirect_pc, RESET_PC);
    check("rst_badaddr", badaddr, 32'd0);
    RST = 1'b0;
    tick();

    // Illegal instruction, no stall, privilege reply in the REPORT cycle.
    mem_valid = 1'b1; mem_pc = 32'h1000; mem_flags = B_ILL;
    push_rep(B_ILL, 32'h1000, 32'h1000, 1'b1);
    #1 check("ill_wb_enable", 32'(wb_enable), 32'd0);
    tick();
    check("ill_report", 32'(illegal_insn), 32'd1);
    check("ill_flush", 32'(flush_all), 32'd1);
    idle_inputs(); insert_pc = 1'b1; priv_pc = 32'h80; redir_sb.push_back(32'h80);
    tick();
    check("ill_redirect_valid", 32'(redirect_valid), 32'd1);
    check("ill_redirect_flush", 32'(flush_all), 32'd1);
    insert_pc = 1'b0;
    tick();
    check("ill_back_idle", 32'(redirect_valid), 32'd0);
    check("idle_wb_enable", 32'(wb_enable), 32'd1);

    // Load fault behind a 3-cycle data stall; insert_pc then held high for several cycles.
    mem_valid = 1'b1; mem_pc = 32'h3000; mem_flags = B_FL; mem_daddr = 32'hDEAD_BEE0;
    ex_mem_stall = 1'b1;
    push_rep(B_FL, 32'h3000, 32'hDEAD_BEE0, 1'b1);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain%0d_hold", i), 32'(hold_pipe), 32'd1);
      check($sformatf("drain%0d_no_clear", i), 32'(pipe_clear), 32'd0);
      check($sformatf("drain%0d_wb", i), 32'(wb_enable), 32'd0);
      if (i == 2) ex_mem_stall = 1'b0;
      tick();
    end
    check("lf_report", 32'(fault_l), 32'd1);
    check("lf_badaddr", badaddr, 32'hDEAD_BEE0);
    check("lf_report_no_hold", 32'(hold_pipe), 32'd0);
    tick();
    check("lf_await_hold", 32'(hold_pipe), 32'd1);
    tick();
    check("lf_await_hold2", 32'(hold_pipe), 32'd1);
    check("lf_await_no_redirect", 32'(redirect_valid), 32'd0);
    insert_pc = 1'b1; priv_pc = 32'h400; redir_sb.push_back(32'h400);
    tick();
    check("lf_redirect_valid", 32'(redirect_valid), 32'd1);
    tick();
    check("lf_single_redirect_a", 32'(redirect_valid), 32'd0);
    tick();
    check("lf_single_redirect_b", 32'(redirect_valid), 32'd0);
    insert_pc = 1'b0;
    tick();

    // Interrupt beats simultaneous breakpoint and store misalignment.
    mem_valid = 1'b1; mem_pc = 32'h4000; mem_flags = B_MS | B_BRK; mem_daddr = 32'h55AA; intr = 1'b1;
    push_rep(11'h000, 32'h4000, 32'd0, 1'b1);
    #1 check("intr_wb_enable", 32'(wb_enable), 32'd0);
    tick();
    check("intr_pipe_clear", 32'(pipe_clear), 32'd1);
    idle_inputs(); insert_pc = 1'b1; priv_pc = 32'h800; redir_sb.push_back(32'h800);
    tick();
    check("intr_redirect_valid", 32'(redirect_valid), 32'd1);
    insert_pc = 1'b0;
    tick();

    // WFI: one-cycle wfi report, sleep with the pipe held, wake on interrupt with epc = pc + 4.
    mem_valid = 1'b1; mem_pc = 32'h2000; mem_flags = B_WFI;
    push_rep(B_WFI, 32'h2000, 32'd0, 1'b1);
    tick();
    check("wfi_pulse", 32'(wfi), 32'd1);
    check("wfi_hold", 32'(hold_pipe), 32'd1);
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      mem_valid = (i == 3); mem_flags = (i == 3) ? B_ILL : 11'h000;
      tick();
      check($sformatf("sleep%0d_hold", i), 32'(hold_pipe), 32'd1);
      check($sformatf("sleep%0d_wfi_low", i), 32'(wfi), 32'd0);
    end
    idle_inputs(); intr = 1'b1;
    push_rep(11'h000, 32'h2004, 32'd0, 1'b1);
    tick();
    check("wake_epc", epc, 32'h2004);
    intr = 1'b0;
    tick();
    check("wake_await_hold", 32'(hold_pipe), 32'd1);
    insert_pc = 1'b1; priv_pc = 32'h100; redir_sb.push_back(32'h100);
    tick();
    check("wake_redirect_valid", 32'(redirect_valid), 32'd1);
    insert_pc = 1'b0;
    tick();

    // Reset while awaiting the privilege reply aborts the sequence.
    mem_valid = 1'b1; mem_pc = 32'h5000; mem_flags = B_ENV;
    push_rep(B_ENV, 32'h5000, 32'd0, 1'b1);
    tick();
    idle_inputs();
    tick();
    check("abort_await_hold", 32'(hold_pipe), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("abort_hold", 32'(hold_pipe), 32'd0);
    check("abort_flush", 32'(flush_all), 32'd0);
    check("abort_redirect_valid", 32'(redirect_valid), 32'd0);
    check("abort_pipe_clear", 32'(pipe_clear), 32'd0);
    check("abort_report", 32'(rep), 32'd0);
    check("abort_wb_enable", 32'(wb_enable), 32'd1);
    check("abort_epc", epc, RESET_PC);
    check("abort_badaddr", badaddr, 32'd0);
    check("abort_redirect_pc", redirect_pc, RESET_PC);
    tick();
    RST = 1'b0; insert_pc = 1'b1; priv_pc = 32'h900;
    tick();
    check("abort_no_redirect_a", 32'(redirect_valid), 32'd0);
    tick();
    check("abort_no_redirect_b", 32'(redirect_valid), 32'd0);
    insert_pc = 1'b0;
    tick();

    // Cause table: priority pairs, protection-fault merging and badaddr source.
    for (int k = 0; k < 12; k++) begin
      mem_valid = 1'b1; mem_pc = 32'h6000 + 32'(k) * 32'd16; mem_daddr = 32'hA000_0000 + 32'(k);
      mem_flags = tbl[k].flags; prot = tbl[k].prot;
      case (tbl[k].bk)
        2'd1:    bad = mem_pc;
        2'd2:    bad = mem_daddr;
        default: bad = 32'd0;
      endcase
      push_rep(tbl[k].exp, mem_pc, bad, tbl[k].bk != 2'd3);
      #1 check($sformatf("tbl%0d_wb_enable", k), 32'(wb_enable), (tbl[k].exp == B_RET) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("tbl%0d_pipe_clear", k), 32'(pipe_clear), 32'd1);
      idle_inputs(); insert_pc = 1'b1; priv_pc = 32'hC000 + 32'(k); redir_sb.push_back(32'hC000 + 32'(k));
      tick();
      check($sformatf("tbl%0d_redirect_valid", k), 32'(redirect_valid), 32'd1);
      insert_pc = 1'b0;
      tick();
    end

    tick();
    check("report_queue_drained", 32'(rep_sb.size()), 32'd0);
    check("redirect_queue_drained", 32'(redir_sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
